// File: rtl/udp_tx_framer_if.sv
// Request/status and FIFO-side signals of the UDP transmit framer.
// The master side is the environment; the slave side is the framer.
interface udp_tx_framer_if;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        err;
    logic        in_rd_en;
    logic [7:0]  in_dout;
    logic        in_empty;
    logic        out_wr_en;
    logic        out_wr_sof;
    logic        out_wr_eof;
    logic [7:0]  out_din;
    logic        out_full;

    modport master (
        output start, len, in_dout, in_empty, out_full,
        input  busy, err, in_rd_en, out_wr_en, out_wr_sof, out_wr_eof, out_din
    );

    modport slave (
        input  start, len, in_dout, in_empty, out_full,
        output busy, err, in_rd_en, out_wr_en, out_wr_sof, out_wr_eof, out_din
    );
endinterface

// File: rtl/udp_tx_framer.sv
// Builds an Ethernet II / IPv4 / UDP frame around a payload from an FWFT FIFO,
// one byte per clock into a downstream FIFO, with sof/eof framing.
module udp_tx_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_0101,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0102,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd6000,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input logic           clock,
    input logic           reset,
    udp_tx_framer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, HDR, PAY} state_t;

    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] LAST_HDR = 16'd41;

    state_t      state;
    logic [15:0] n;
    logic [15:0] cnt;
    logic [15:0] ip_id;
    logic [15:0] hdr_csum;
    logic        err_q;

    logic [15:0]  total_len;
    logic [15:0]  udp_len;
    logic [31:0]  csum_acc;
    logic [31:0]  csum_f1;
    logic [31:0]  csum_f2;
    logic [335:0] hdr;
    logic [5:0]   hdr_idx;
    logic [7:0]   hdr_byte;

    logic       wr_en;
    logic       rd_en;
    logic       sof;
    logic       eof;
    logic [7:0] din;

    assign total_len = n + 16'd28;
    assign udp_len   = n + 16'd8;

    // One's-complement sum over the fixed and per-packet IPv4 header words.
    assign csum_acc = 32'h4500 + 32'(total_len) + 32'(ip_id) + 32'h4000 + 32'h4011
                    + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
                    + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
    assign csum_f1  = {16'h0, csum_acc[15:0]} + {16'h0, csum_acc[31:16]};
    assign csum_f2  = {16'h0, csum_f1[15:0]}  + {16'h0, csum_f1[31:16]};

    assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                  8'h45, 8'h00, total_len, ip_id, 16'h4000, 8'h40, 8'h11, hdr_csum,
                  SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, udp_len, 16'h0000};

    // Byte 0 sits in the top byte lane of the packed header.
    assign hdr_idx  = 6'd41 - cnt[5:0];
    assign hdr_byte = hdr[{hdr_idx, 3'b000} +: 8];

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        sof   = 1'b0;
        eof   = 1'b0;
        din   = 8'h00;
        unique case (state)
            HDR: begin
                wr_en = !bus.out_full;
                din   = hdr_byte;
                sof   = wr_en && (cnt == 16'd0);
                eof   = wr_en && (cnt == LAST_HDR) && (n == 16'd0);
            end
            PAY: begin
                wr_en = !bus.out_full && !bus.in_empty;
                rd_en = wr_en;
                din   = bus.in_dout;
                eof   = wr_en && (cnt == n - 16'd1);
            end
            default: ;
        endcase
    end

    assign bus.out_wr_en  = wr_en;
    assign bus.in_rd_en   = rd_en;
    assign bus.out_wr_sof = sof;
    assign bus.out_wr_eof = eof;
    assign bus.out_din    = din;
    assign bus.busy       = (state != IDLE);
    assign bus.err        = err_q;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n        <= 16'd0;
            cnt      <= 16'd0;
            ip_id    <= 16'd0;
            hdr_csum <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len > MAX_LEN) begin
                            err_q <= 1'b1;
                        end else begin
                            n     <= bus.len;
                            cnt   <= 16'd0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hdr_csum <= ~csum_f2[15:0];
                    state    <= HDR;
                end
                HDR: begin
                    if (wr_en) begin
                        if (cnt == LAST_HDR) begin
                            cnt <= 16'd0;
                            if (n == 16'd0) begin
                                state <= IDLE;
                                ip_id <= ip_id + 16'd1;
                            end else begin
                                state <= PAY;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                PAY: begin
                    if (wr_en) begin
                        if (eof) begin
                            cnt   <= 16'd0;
                            state <= IDLE;
                            ip_id <= ip_id + 16'd1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Scoreboard bench for udp_tx_framer: a frame-level model queues expected bytes,
// a monitor pops and compares every byte the framer writes.
module tb_udp_tx_framer;

    localparam logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC  = 48'h0200_0000_0001;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0101;
    localparam logic [31:0] DST_IP   = 32'hC0A8_0102;
    localparam logic [15:0] SRC_PORT = 16'd5000;
    localparam logic [15:0] DST_PORT = 16'd6000;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    udp_tx_framer_if bus();

    udp_tx_framer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    beat_t      exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] act_frame[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int wr_total  = 0;
    int rd_total  = 0;
    int eof_count = 0;
    int sof_cyc   = 0;
    int eof_cyc   = 0;
    int start_cyc = 0;
    int idle_cyc  = 0;

    logic [15:0] exp_id = 16'd0;

    bit rand_full   = 1'b0;
    int full_pct    = 0;
    int empty_hold  = 0;
    bit stall_armed = 1'b0;
    int stall_mark  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ip_csum(input int n, input logic [15:0] id);
        int unsigned s;
        s = 32'h4500 + 32'(n + 28) + 32'(id) + 32'h4000 + 32'h4011
          + (SRC_IP >> 16) + (SRC_IP & 32'hFFFF) + (DST_IP >> 16) + (DST_IP & 32'hFFFF);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~16'(s);
    endfunction

    // Expected frame: header fields listed with byte widths, then the payload.
    task automatic send_packet(input int n, input bit rnd);
        logic [47:0] fv[17];
        int          fw[17];
        logic [7:0]  hb[$];
        logic [7:0]  b;
        fv = '{DST_MAC, SRC_MAC, 48'h0800, 48'h45, 48'h00, 48'(n + 28), 48'(exp_id),
               48'h4000, 48'h40, 48'h11, 48'(ip_csum(n, exp_id)), 48'(SRC_IP), 48'(DST_IP),
               48'(SRC_PORT), 48'(DST_PORT), 48'(n + 8), 48'h0};
        fw = '{6, 6, 2, 1, 1, 2, 2, 2, 1, 1, 2, 4, 4, 2, 2, 2, 2};
        for (int f = 0; f < 17; f++)
            for (int k = fw[f] - 1; k >= 0; k--)
                hb.push_back(8'(fv[f] >> (8 * k)));
        for (int i = 0; i < 42; i++)
            exp_q.push_back(beat_t'{data: hb[i], sof: (i == 0), eof: (i == 41 && n == 0)});
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            pay_q.push_back(b);
            exp_q.push_back(beat_t'{data: b, sof: 1'b0, eof: (i == n - 1)});
        end
        exp_id = exp_id + 16'd1;
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.len   = 16'(n);
        start_cyc = cyc;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || bus.busy) && i < budget) begin
            @(negedge clock); #1;
            i++;
        end
        idle_cyc = cyc;
        if (i >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending bytes expected 0", exp_q.size());
        end
    endtask

    task automatic wait_writes(input int target, input int budget);
        int i = 0;
        while (wr_total < target && i < budget) begin
            @(negedge clock); #1;
            i++;
        end
        if (i >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_wait: got %0d writes expected %0d", wr_total, target);
        end
    endtask

    // Source and sink FIFO models: inputs change only just after the rising edge.
    initial begin : env
        bit rd;
        bus.start    = 1'b0;
        bus.len      = 16'd0;
        bus.out_full = 1'b0;
        bus.in_empty = 1'b1;
        bus.in_dout  = 8'h00;
        forever begin
            @(negedge clock);
            rd = bus.in_rd_en && reset;
            @(posedge clock); #1;
            if (rd && pay_q.size() > 0) void'(pay_q.pop_front());
            bus.out_full = rand_full && ($urandom_range(99) < full_pct);
            if (stall_armed && rd_total >= stall_mark) begin
                empty_hold  = 5;
                stall_armed = 1'b0;
            end
            if (empty_hold > 0) begin
                bus.in_empty = 1'b1;
                empty_hold--;
            end else begin
                bus.in_empty = (pay_q.size() == 0);
            end
            bus.in_dout = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
        end
    end

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (bus.in_rd_en) begin
                    rd_total++;
                    check("read_while_empty", 32'(bus.in_empty), 32'd0);
                end
                if (bus.out_wr_en) begin
                    wr_total++;
                    check("write_while_full", 32'(bus.out_full), 32'd0);
                    if (bus.out_wr_sof) begin
                        act_frame.delete();
                        sof_cyc = cyc;
                    end
                    act_frame.push_back(bus.out_din);
                    if (bus.out_wr_eof) begin
                        eof_cyc = cyc;
                        eof_count++;
                    end
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got byte %0h expected no write", bus.out_din);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_beat", 32'({bus.out_din, bus.out_wr_sof, bus.out_wr_eof}), 32'(e));
                    end
                end
            end
        end
    end

    initial begin : main
        int w0;
        int r0;
        int ec;
        int i;
        int first_eof;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_outs", 32'({bus.out_wr_en, bus.in_rd_en, bus.out_wr_sof, bus.out_wr_eof, bus.out_din}), 32'd0);
        reset = 1'b1;

        // Basic len=10 frame, no backpressure
        send_packet(10, 1'b0);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        wait_done(500);
        check("first_write_latency", 32'(sof_cyc - start_cyc), 32'd2);
        check("frame_cycles", 32'(eof_cyc - sof_cyc + 1), 32'd52);
        check("busy_fall", 32'(idle_cyc - eof_cyc), 32'd1);
        check("frame_len", 32'(act_frame.size()), 32'd52);
        check("total_len", 32'({act_frame[16], act_frame[17]}), 32'h0026);
        check("hdr_csum_id0", 32'({act_frame[24], act_frame[25]}), 32'hB773);
        check("udp_len", 32'({act_frame[38], act_frame[39]}), 32'h0012);

        // Back-to-back: second start in the cycle after eof
        ec = eof_count;
        send_packet(10, 1'b0);
        i = 0;
        while (eof_count == ec && i < 500) begin
            @(negedge clock); #1;
            i++;
        end
        first_eof = eof_cyc;
        check("id1", 32'({act_frame[18], act_frame[19]}), 32'h0001);
        check("hdr_csum_id1", 32'({act_frame[24], act_frame[25]}), 32'hB772);
        send_packet(10, 1'b0);
        check("b2b_no_err", 32'(bus.err), 32'd0);
        wait_done(500);
        check("b2b_gap", 32'(sof_cyc - first_eof), 32'd3);
        check("id2", 32'({act_frame[18], act_frame[19]}), 32'h0002);

        // Zero-length payload
        r0 = rd_total;
        send_packet(0, 1'b0);
        wait_done(500);
        check("len0_size", 32'(act_frame.size()), 32'd42);
        check("len0_total_len", 32'({act_frame[16], act_frame[17]}), 32'h001C);
        check("len0_udp_len", 32'({act_frame[38], act_frame[39]}), 32'h0008);
        check("len0_no_reads", 32'(rd_total - r0), 32'd0);

        // Random backpressure plus a 5-cycle empty stall mid-payload
        rand_full   = 1'b1;
        full_pct    = 30;
        stall_mark  = rd_total + 5;
        stall_armed = 1'b1;
        send_packet(40, 1'b1);
        wait_done(2000);
        for (int k = 0; k < 4; k++) begin
            send_packet(int'($urandom_range(64)), 1'b1);
            wait_done(2000);
        end
        rand_full = 1'b0;

        // Largest accepted payload
        send_packet(1472, 1'b1);
        wait_done(5000);
        check("max_frame_len", 32'(act_frame.size()), 32'd1514);

        // Oversized request is rejected
        w0 = wr_total;
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.len   = 16'd1473;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("err_pulse", 32'(bus.err), 32'd1);
        check("err_busy", 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        check("err_one_cycle", 32'(bus.err), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        check("err_no_writes", 32'(wr_total - w0), 32'd0);
        check("err_still_idle", 32'(bus.busy), 32'd0);

        // Starts while busy are ignored
        w0 = wr_total;
        send_packet(10, 1'b0);
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.len   = 16'd5;
        @(posedge clock); #1;
        check("busy_start_no_err", 32'(bus.err), 32'd0);
        bus.len = 16'd1473;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("busy_bad_len_no_err", 32'(bus.err), 32'd0);
        wait_done(500);
        repeat (5) @(posedge clock);
        #1;
        check("busy_start_ignored", 32'(wr_total - w0), 32'd52);

        // Reset at header byte 20
        w0 = wr_total;
        send_packet(10, 1'b0);
        wait_writes(w0 + 20, 500);
        @(posedge clock); #1;
        check("pre_reset_write", 32'(bus.out_wr_en), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_outs", 32'({bus.busy, bus.out_wr_en, bus.in_rd_en, bus.out_wr_sof, bus.out_wr_eof, bus.out_din}), 32'd0);
        exp_q.delete();
        pay_q.delete();
        exp_id = 16'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        send_packet(10, 1'b0);
        wait_done(500);
        check("post_rst_id", 32'({act_frame[18], act_frame[19]}), 32'h0000);
        check("post_rst_csum", 32'({act_frame[24], act_frame[25]}), 32'hB773);
        check("post_rst_len", 32'(act_frame.size()), 32'd52);

        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
- Transmit-side counterpart of the UDP packet parser (udp_top).
- Takes a payload length and a payload byte stream from a first-word-fall-through (FWFT) FIFO.
- Emits a complete Ethernet II / IPv4 / UDP frame, one byte per clock, into a downstream FIFO. Byte 0 of each frame is flagged with sof and the last byte with eof, matching the parser's input framing (wr_en/wr_sof/wr_eof/full).
- Header fields are fixed by parameters. The IPv4 header checksum and the ID field are generated per packet.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC
SRC_MAC, 48'h0200_0000_0001, source MAC
SRC_IP, 32'hC0A8_0101, source IPv4 (192.168.1.1)
DST_IP, 32'hC0A8_0102, destination IPv4 (192.168.1.2)
SRC_PORT, 16'd5000, UDP source port
DST_PORT, 16'd6000, UDP destination port
MAX_PAYLOAD, 1472, largest accepted payload length in bytes

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to build one packet
len  in  16  payload length N in bytes; sampled with start
busy  out  1  high from start accept until the eof byte is written
err  out  1  one-cycle pulse: start rejected because len > MAX_PAYLOAD
in_rd_en  out  1  pop payload FIFO
in_dout  in  8  payload byte (FWFT; valid while !in_empty)
in_empty  in  1  payload FIFO empty
out_wr_en  out  1  write byte to downstream FIFO
out_wr_sof  out  1  first byte of frame (qualified by out_wr_en)
out_wr_eof  out  1  last byte of frame (qualified by out_wr_en)
out_din  out  8  frame byte
out_full  in  1  downstream FIFO full

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, busy=0, err=0, in_rd_en=0, out_wr_en=0, out_wr_sof=0, out_wr_eof=0, out_din=0.
  - IP ID counter=0; byte counter=0.
- Frame layout (42+N bytes, transmitted MSB-first within each field):
  - Bytes 0-13: DST_MAC, SRC_MAC, 16'h0800.
  - Bytes 14-33: 8'h45, 8'h00, total_len=20+8+N, ID, 16'h4000, TTL 8'h40, proto 8'h11, hdr_csum, SRC_IP, DST_IP.
  - Bytes 34-41: SRC_PORT, DST_PORT, udp_len=8+N, 16'h0000 (UDP checksum disabled).
  - Bytes 42..42+N-1: payload.
- State machine: IDLE -> CALC -> HDR -> PAY -> IDLE.
  - IDLE:
    - start=1 with len<=MAX_PAYLOAD: latch N and go to CALC; busy=1 from the next cycle.
    - start=1 with len>MAX_PAYLOAD: pulse err for one cycle and stay in IDLE.
  - CALC (1 cycle): hdr_csum = ~fold(sum of 16-bit words 4500, total_len, ID, 4000, 4011, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]). fold = add bits[31:16] into bits[15:0] twice; 32-bit accumulator.
  - HDR:
    - out_wr_en = !out_full; out_din = header byte[cnt]; cnt advances only on a write.
    - out_wr_sof=1 at cnt=0.
    - At cnt=41: if N=0, out_wr_eof=1 and go to IDLE; otherwise go to PAY.
  - PAY:
    - out_wr_en = in_rd_en = !out_full && !in_empty; out_din = in_dout.
    - out_wr_eof=1 on payload byte N-1; then go to IDLE.
- Exiting to IDLE after the eof write: busy=0 and ID increments by 1 (16-bit, wraps FFFF->0000).
- Write/read signals (out_wr_en, out_din, sof, eof, in_rd_en) are combinational from the state registers and out_full/in_empty. No write is issued while out_full=1. in_rd_en is never asserted outside PAY.
- Throughput and latency:
  - First out_wr_en occurs in the second cycle after start is accepted.
  - With out_full=0 and payload available, the frame occupies exactly 42+N consecutive cycles.
  - Back-to-back: a start in the cycle after eof is accepted.
- Boundaries:
  - start while busy=1: ignored, no err.
  - Stalls on out_full or in_empty may occur at any byte, including sof/eof bytes. They hold all counters and state.
  - N=0: frame is 42 bytes with eof on byte 41.
  - N=MAX_PAYLOAD: accepted. N=MAX_PAYLOAD+1: rejected.
- Reset mid-frame: immediate return to IDLE, ID cleared, no eof is emitted. The downstream consumer discards any open (sof without eof) frame.

Test Plan:
- Default params, ID=0, len=10, payload 00..09, no backpressure -> 52 bytes in 52 consecutive cycles; bytes 16-17=0026, 24-25=B773, 38-39=0012; sof on byte 0 only, eof on byte 51 only; busy falls after byte 51.
- Same packet sent twice back-to-back -> second frame has ID=0001 (bytes 18-19) and checksum B772.
- len=0 -> 42-byte frame, total_len=001C, udp_len=0008, eof on byte 41, in_rd_en never asserted.
- out_full toggled randomly and in_empty held high for 5 cycles mid-payload -> byte sequence identical to the unstalled run; no write while out_full=1; no read while in_empty=1.
- len=1473 -> err pulses one cycle, busy stays 0, no writes. A start with busy=1 is ignored.
- reset asserted at header byte 20 -> all outputs 0 asynchronously. A subsequent len=10 request produces a full frame with ID=0000.
